// File: rtl/data_connect_fifo_pipe.sv
// Elastic valid/ready pipe with DEPTH entries. It supports full throughput, clock-enable
// qualification, flush, occupancy/almost-full status and a sticky handshake-violation flag.
module data_connect_fifo_pipe #(
    parameter int unsigned DSIZE    = 8,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned AF_LEVEL = 1
) (
    input  logic                           clock,
    input  logic                           rst,
    input  logic                           clk_en,
    input  logic                           flush,
    input  logic                           from_up_vld,
    input  logic [DSIZE-1:0]               from_up_data,
    output logic                           to_up_ready,
    input  logic                           from_down_ready,
    output logic                           to_down_vld,
    output logic [DSIZE-1:0]               to_down_data,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           almost_full,
    output logic                           over_flow
);

    localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW     = $clog2(DEPTH + 1);
    localparam int unsigned AF_THR = DEPTH - AF_LEVEL;

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_ACTIVE = 2'd1,
        S_FULL   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DSIZE-1:0]    r_mem [DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [DSIZE-1:0]    r_dout;
    logic                r_up_ready;
    logic                r_down_vld;
    logic                r_almost_full;
    logic                r_over_flow;
    logic                r_stall;
    logic [DSIZE-1:0]    r_stall_data;

    logic                w_push;
    logic                w_pop;
    logic [PW-1:0]       w_wr_nxt;
    logic [PW-1:0]       w_rd_nxt;
    logic [CW-1:0]       w_count_nxt;
    logic [DSIZE-1:0]    w_head_nxt;
    logic                w_violation;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Transfers are decoded from state only; flush discards any same-cycle transfer.
    assign w_push = clk_en & ~flush & from_up_vld     & (r_state != S_FULL);
    assign w_pop  = clk_en & ~flush & from_down_ready & (r_state != S_EMPTY);

    // Next-state, pointer and occupancy decode.
    always_comb begin
        w_state_nxt = r_state;
        w_wr_nxt    = r_wr_ptr;
        w_rd_nxt    = r_rd_ptr;
        w_count_nxt = r_count;

        if (w_push) w_wr_nxt = ptr_inc(r_wr_ptr);
        if (w_pop)  w_rd_nxt = ptr_inc(r_rd_ptr);

        if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
        else if (w_pop && !w_push) w_count_nxt = r_count - CW'(1);

        case (r_state)
            S_EMPTY: begin
                if (w_push) w_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (w_push && !w_pop && (r_count == CW'(DEPTH - 1)))
                    w_state_nxt = S_FULL;
                else if (w_pop && !w_push && (r_count == CW'(1)))
                    w_state_nxt = S_EMPTY;
            end
            S_FULL: begin
                if (w_pop) w_state_nxt = S_ACTIVE;
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // The new head bypasses from the input when it is being written this cycle.
    always_comb begin
        w_head_nxt = r_mem[w_rd_nxt];
        if (w_push && (w_rd_nxt == r_wr_ptr))
            w_head_nxt = from_up_data;
    end

    // A stalled offer seen last enabled cycle must be repeated unchanged.
    assign w_violation = r_stall & (~from_up_vld | (from_up_data != r_stall_data));

    // State register.
    always_ff @(posedge clock) begin
        if (rst)
            r_state <= S_EMPTY;
        else if (clk_en)
            r_state <= flush ? S_EMPTY : w_state_nxt;
    end

    // Storage array; contents need no reset because valid tracking covers them.
    always_ff @(posedge clock) begin
        if (!rst && w_push)
            r_mem[r_wr_ptr] <= from_up_data;
    end

    // Pointers, occupancy, registered outputs and protocol monitor.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_dout        <= '0;
            r_up_ready    <= 1'b1;
            r_down_vld    <= 1'b0;
            r_almost_full <= (AF_THR == 0);
            r_over_flow   <= 1'b0;
            r_stall       <= 1'b0;
            r_stall_data  <= '0;
        end else if (clk_en) begin
            if (flush) begin
                r_wr_ptr      <= '0;
                r_rd_ptr      <= '0;
                r_count       <= '0;
                r_up_ready    <= 1'b1;
                r_down_vld    <= 1'b0;
                r_almost_full <= (AF_THR == 0);
                r_over_flow   <= 1'b0;
                r_stall       <= 1'b0;
            end else begin
                r_wr_ptr      <= w_wr_nxt;
                r_rd_ptr      <= w_rd_nxt;
                r_count       <= w_count_nxt;
                r_up_ready    <= (w_state_nxt != S_FULL);
                r_down_vld    <= (w_state_nxt != S_EMPTY);
                r_almost_full <= (w_count_nxt >= CW'(AF_THR));
                r_over_flow   <= r_over_flow | w_violation;
                r_stall       <= from_up_vld & (r_state == S_FULL);
                if (w_push || w_pop)
                    r_dout <= w_head_nxt;
            end
            r_stall_data <= from_up_data;
        end
    end

    assign to_up_ready  = r_up_ready;
    assign to_down_vld  = r_down_vld;
    assign to_down_data = r_dout;
    assign count        = r_count;
    assign almost_full  = r_almost_full;
    assign over_flow    = r_over_flow;

endmodule
